// File: rtl/adc_spi_responder_if.sv
// SPI pins and sample/command handshake signals of the ADC SPI responder.
//   spi_cs_n, spi_sck, spi_mosi : SPI master pins (mode 0)
//   spi_miso, spi_miso_oe       : SPI slave data out and its output enable
//   sample_data/valid/ready     : conversion result handshake into the holding register
//   cmd_data, cmd_valid         : command bits received at the start of each frame
//   frame_error                 : one-clk pulse when a frame is cut short by CS
// The slave modport is used by the responder, the master modport by whoever drives it.
interface adc_spi_responder_if #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_BITS  = 12
);
  logic                           spi_cs_n;
  logic                           spi_sck;
  logic                           spi_mosi;
  logic                           spi_miso;
  logic                           spi_miso_oe;
  logic [DATA_BITS-1:0]           sample_data;
  logic                           sample_valid;
  logic                           sample_ready;
  logic [FRAME_BITS-DATA_BITS-1:0] cmd_data;
  logic                           cmd_valid;
  logic                           frame_error;

  modport slave (
    input  spi_cs_n, spi_sck, spi_mosi, sample_data, sample_valid,
    output spi_miso, spi_miso_oe, sample_ready, cmd_data, cmd_valid, frame_error
  );

  modport master (
    output spi_cs_n, spi_sck, spi_mosi, sample_data, sample_valid,
    input  spi_miso, spi_miso_oe, sample_ready, cmd_data, cmd_valid, frame_error
  );
endinterface

// File: rtl/adc_spi_responder.sv
// SPI mode-0 slave that returns one held ADC sample per frame and captures the command bits
// the master sends in the first FRAME_BITS-DATA_BITS MOSI bits.
//   clk   : system clock, at least 4x SCK
//   reset : synchronous, active-high
//   bus   : adc_spi_responder_if slave modport (SPI pins, sample handshake, cmd/error outputs)
// Frame word on MISO, MSB first: {empty, zeros, sample}, where empty=1 and sample=0 when no
// sample was held at the start of the frame.
module adc_spi_responder #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset,
  adc_spi_responder_if.slave bus
);

  localparam int unsigned CMD_BITS = FRAME_BITS - DATA_BITS;
  localparam int unsigned CNT_W    = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Input synchronizers; the last stage is the only view of the pins used anywhere.
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;

  state_e                state_q, state_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic                  frame_err_q, frame_err_d;
  logic                  oe_q, oe_d;
  logic                  sample_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(bus.spi_cs_n);
      sck_sync_q  <= (sck_sync_q << 1) | SYNC_STAGES'(bus.spi_sck);
      mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(bus.spi_mosi);
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  assign sample_ready = ~hold_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      frame_err_q <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      frame_err_q <= frame_err_d;
      oe_q        <= oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    frame_err_d = 1'b0;
    oe_d        = oe_q;

    // A CS rise ends the driven window whether the frame completed or was aborted.
    if (cs_rise) begin
      oe_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d                = StShift;
          cnt_d                  = '0;
          tx_d                   = '0;
          tx_d[FRAME_BITS-1]     = ~hold_full_q;
          if (hold_full_q) begin
            tx_d[DATA_BITS-1:0] = hold_q;
          end
          hold_full_d            = 1'b0;
          oe_d                   = 1'b1;
        end
      end
      StShift: begin
        if (cs_rise) begin
          // Sample already left the holding register; it is dropped, not returned.
          frame_err_d = (cnt_q < CNT_W'(FRAME_BITS));
          state_d     = StIdle;
        end else if (sck_rise) begin
          rx_d  = {rx_q[FRAME_BITS-2:0], mosi_s};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(FRAME_BITS)) begin
            state_d = StDone;
            cmd_d   = rx_d[FRAME_BITS-1:DATA_BITS];
          end
        end else if (sck_fall) begin
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Evaluated after the frame-start clear: a sample arriving on the CS-fall cycle
    // waits in the holding register for the next frame.
    if (sample_ready && bus.sample_valid) begin
      hold_d      = bus.sample_data;
      hold_full_d = 1'b1;
    end
  end

  assign bus.spi_miso     = oe_q & tx_q[FRAME_BITS-1];
  assign bus.spi_miso_oe  = oe_q;
  assign bus.sample_ready = sample_ready;
  assign bus.cmd_data     = cmd_q;
  assign bus.cmd_valid    = (state_q == StDone);
  assign bus.frame_error  = frame_err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a transaction-level model (holding register contents,
// expected frame word, expected command) is checked every clk, and each scenario also has
// hand-computed literal expectations.
module tb_adc_spi_responder;

  localparam int unsigned FB = 16;
  localparam int unsigned DB = 12;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  adc_spi_responder_if #(.FRAME_BITS(FB), .DATA_BITS(DB)) bus ();

  adc_spi_responder #(
    .FRAME_BITS (FB),
    .DATA_BITS  (DB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model state
  bit          armed      = 1'b0;
  logic        held_v     = 1'b0;
  logic [11:0] held_d     = '0;
  logic [15:0] frame_exp  = '0;
  logic [3:0]  model_cmd  = '0;
  logic [3:0]  cmd_next   = '0;
  int          start_req  = 0;
  int          start_ack  = 0;
  int          hs_cnt     = 0;
  int          cv_cnt     = 0;
  int          fe_cnt     = 0;
  logic        prev_cv    = 1'b0;
  logic        prev_fe    = 1'b0;

  // Frame content is fixed by the holding register as it stood before the CS-fall action edge.
  always @(posedge clk) begin
    if (reset) begin
      held_v    <= 1'b0;
      held_d    <= '0;
      model_cmd <= '0;
      start_ack <= start_req;
    end else begin
      if (start_ack != start_req) begin
        frame_exp <= held_v ? {4'h0, held_d} : 16'h8000;
        held_v    <= 1'b0;
        start_ack <= start_req;
      end
      if (bus.sample_valid && !held_v) begin
        held_v <= 1'b1;
        held_d <= bus.sample_data;
        hs_cnt <= hs_cnt + 1;
      end
      if (bus.cmd_valid) model_cmd <= cmd_next;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("miso_zero_when_oe_low", {31'b0, bus.spi_miso & ~bus.spi_miso_oe}, 32'h0);
      chk("sample_ready", {31'b0, bus.sample_ready}, {31'b0, ~held_v});
      chk("cmd_data", {28'b0, bus.cmd_data}, {28'b0, bus.cmd_valid ? cmd_next : model_cmd});
      chk("cmd_valid_one_clk", {31'b0, bus.cmd_valid & prev_cv}, 32'h0);
      chk("frame_error_one_clk", {31'b0, bus.frame_error & prev_fe}, 32'h0);
      if (bus.cmd_valid) cv_cnt++;
      if (bus.frame_error) fe_cnt++;
      prev_cv = bus.cmd_valid;
      prev_fe = bus.frame_error;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_sample(input logic [11:0] d);
    int h0;
    h0 = hs_cnt;
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    for (int i = 0; i < 20 && hs_cnt == h0; i++) wait_clks(1);
    bus.sample_valid = 1'b0;
    chk("load_handshake", hs_cnt - h0, 32'd1);
  endtask

  // One SPI frame: bit b rises at s+2hb, falls h later; MISO for bit b is read 3 clk after its
  // rise, once the responder has acted on that rise and before it can act on the next fall.
  task automatic run_frame(input logic [15:0] mosi_w, input int nbits, input int h,
                           input bit keep_cs, input bit inject, input logic [11:0] inj_d,
                           output logic [15:0] miso_w);
    int s, last_rise, cs_up, t_end, h0, r;
    s         = 8;
    last_rise = s + 2 * h * (nbits - 1);
    cs_up     = last_rise + h + 2;
    t_end     = keep_cs ? last_rise + h : cs_up + 8;
    h0        = hs_cnt;
    miso_w    = '0;
    for (int t = 0; t <= t_end; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        bus.spi_cs_n = 1'b0;
        bus.spi_mosi = mosi_w[15];
      end
      if (t == 2) start_req++;
      if (inject && t == 2) begin
        bus.sample_valid = 1'b1;
        bus.sample_data  = inj_d;
      end
      if (inject && t > 2 && hs_cnt != h0) bus.sample_valid = 1'b0;
      if (t == s) chk("oe_in_frame", {31'b0, bus.spi_miso_oe}, 32'd1);
      for (int b = 0; b < nbits; b++) begin
        r = s + 2 * h * b;
        if (t == r) bus.spi_sck = 1'b1;
        if (t == r + h) begin
          bus.spi_sck  = 1'b0;
          bus.spi_mosi = (b + 1 < 16) ? mosi_w[14 - b] : 1'b0;
        end
        if (t == r + 3 && b < 16) miso_w[15 - b] = bus.spi_miso;
      end
      if (!keep_cs && t == cs_up) bus.spi_cs_n = 1'b1;
    end
    bus.spi_sck      = 1'b0;
    bus.sample_valid = 1'b0;
    if (inject) chk("inject_handshake", hs_cnt - h0, 32'd1);
    if (!keep_cs) chk("oe_after_frame", {31'b0, bus.spi_miso_oe}, 32'd0);
  endtask

  task automatic toggle_sck(input int n, input int h);
    for (int k = 0; k < n; k++) begin
      bus.spi_sck = 1'b1;
      wait_clks(h);
      bus.spi_sck = 1'b0;
      wait_clks(h);
      chk("oe_while_cs_high", {31'b0, bus.spi_miso_oe}, 32'd0);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_miso", {31'b0, bus.spi_miso}, 32'd0);
    chk("rst_miso_oe", {31'b0, bus.spi_miso_oe}, 32'd0);
    chk("rst_cmd_data", {28'b0, bus.cmd_data}, 32'd0);
    chk("rst_cmd_valid", {31'b0, bus.cmd_valid}, 32'd0);
    chk("rst_frame_error", {31'b0, bus.frame_error}, 32'd0);
    chk("rst_sample_ready", {31'b0, bus.sample_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] m;
    int cv0, fe0;
    reset            = 1'b1;
    bus.spi_cs_n     = 1'b1;
    bus.spi_sck      = 1'b0;
    bus.spi_mosi     = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    wait_clks(3);
    armed = 1'b1;
    chk_reset_outputs();
    reset = 1'b0;
    wait_clks(4);

    // Sample A5C, command 3
    load_sample(12'hA5C);
    cmd_next = 4'h3;
    cv0 = cv_cnt;
    run_frame(16'h3000, 16, 4, 1'b0, 1'b0, 12'h0, m);
    chk("f1_miso_model", {16'b0, m}, {16'b0, frame_exp});
    chk("f1_miso_lit", {16'b0, m}, 32'h0A5C);
    chk("f1_cmd_lit", {28'b0, bus.cmd_data}, 32'h3);
    chk("f1_cmd_pulses", cv_cnt - cv0, 32'd1);
    chk("f1_ready_back", {31'b0, bus.sample_ready}, 32'd1);

    // No sample held; two extra SCK cycles after the last bit must be ignored
    cmd_next = 4'hC;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    run_frame(16'hC5A5, 18, 4, 1'b0, 1'b0, 12'h0, m);
    chk("f2_miso_model", {16'b0, m}, {16'b0, frame_exp});
    chk("f2_miso_lit", {16'b0, m}, 32'h8000);
    chk("f2_cmd_lit", {28'b0, bus.cmd_data}, 32'hC);
    chk("f2_cmd_pulses", cv_cnt - cv0, 32'd1);
    chk("f2_no_error", fe_cnt - fe0, 32'd0);

    // Abort after 7 SCK cycles: error, no command, sample discarded
    load_sample(12'h777);
    cmd_next = 4'h9;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    run_frame(16'h9000, 7, 4, 1'b0, 1'b0, 12'h0, m);
    chk("f3_error_pulses", fe_cnt - fe0, 32'd1);
    chk("f3_no_cmd", cv_cnt - cv0, 32'd0);
    chk("f3_cmd_kept", {28'b0, bus.cmd_data}, 32'hC);
    chk("f3_ready", {31'b0, bus.sample_ready}, 32'd1);
    cmd_next = 4'h5;
    run_frame(16'h5000, 16, 4, 1'b0, 1'b0, 12'h0, m);
    chk("f4_miso_lit", {16'b0, m}, 32'h8000);
    chk("f4_cmd_lit", {28'b0, bus.cmd_data}, 32'h5);

    // New sample offered on the CS-fall action cycle waits for the next frame
    load_sample(12'h456);
    cmd_next = 4'h6;
    run_frame(16'h6000, 16, 4, 1'b0, 1'b1, 12'h123, m);
    chk("f5_miso_model", {16'b0, m}, {16'b0, frame_exp});
    chk("f5_miso_lit", {16'b0, m}, 32'h0456);
    cmd_next = 4'h7;
    run_frame(16'h7000, 16, 4, 1'b0, 1'b0, 12'h0, m);
    chk("f6_miso_model", {16'b0, m}, {16'b0, frame_exp});
    chk("f6_miso_lit", {16'b0, m}, 32'h0123);
    chk("f6_cmd_lit", {28'b0, bus.cmd_data}, 32'h7);

    // Reset at SCK cycle 9
    load_sample(12'h321);
    cmd_next = 4'hA;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    run_frame(16'hA000, 9, 4, 1'b1, 1'b0, 12'h0, m);
    reset        = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_sck  = 1'b0;
    wait_clks(2);
    chk_reset_outputs();
    reset = 1'b0;
    wait_clks(6);
    chk("rst_no_error", fe_cnt - fe0, 32'd0);
    chk("rst_no_cmd", cv_cnt - cv0, 32'd0);
    load_sample(12'hFFF);
    cmd_next = 4'h2;
    run_frame(16'h2000, 16, 4, 1'b0, 1'b0, 12'h0, m);
    chk("f7_miso_lit", {16'b0, m}, 32'h0FFF);
    chk("f7_cmd_lit", {28'b0, bus.cmd_data}, 32'h2);

    // SCK toggling with CS high, then normal frames at 8x and exactly 4x
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    toggle_sck(20, 4);
    chk("tog1_no_pulses", (cv_cnt - cv0) + (fe_cnt - fe0), 32'd0);
    load_sample(12'h9AB);
    cmd_next = 4'hE;
    run_frame(16'hE000, 16, 4, 1'b0, 1'b0, 12'h0, m);
    chk("f8_miso_lit", {16'b0, m}, 32'h09AB);
    chk("f8_cmd_lit", {28'b0, bus.cmd_data}, 32'hE);
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    toggle_sck(20, 2);
    chk("tog2_no_pulses", (cv_cnt - cv0) + (fe_cnt - fe0), 32'd0);
    load_sample(12'h0F0);
    cmd_next = 4'h1;
    run_frame(16'h1000, 16, 2, 1'b0, 1'b0, 12'h0, m);
    chk("f9_miso_model", {16'b0, m}, {16'b0, frame_exp});
    chk("f9_miso_lit", {16'b0, m}, 32'h00F0);
    chk("f9_cmd_lit", {28'b0, bus.cmd_data}, 32'h1);
    chk("f9_cmd_pulses", cv_cnt - cv0, 32'd1);

    wait_clks(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 16, meaning SCK cycles per frame.
REQ-002 The block SHALL have parameter DATA_BITS, default 12, meaning sample width, which is also the number of frame LSBs.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the input synchronizer flops on spi_cs_n, spi_sck and spi_mosi.
REQ-004 Port clk  input  1  system clock; the frequency SHALL be at least 4x the SCK frequency.
REQ-005 Port reset  input  1  reset: synchronous, active-high.
REQ-006 Port spi_cs_n  input  1  chip select from the master, active low.
REQ-007 Port spi_sck  input  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
REQ-008 Port spi_mosi  input  1  master-out data, sampled on SCK rising edges.
REQ-009 Port spi_miso  output  1  slave-out data, MSB first.
REQ-010 Port spi_miso_oe  output  1  MISO output enable; high only while a frame is active.
REQ-011 Port sample_data  input  DATA_BITS  conversion result offered by the sampling logic.
REQ-012 Port sample_valid  input  1  sample_data is valid.
REQ-013 Port sample_ready  output  1  the holding register is empty; a transfer occurs when sample_valid and sample_ready are both high.
REQ-014 Port cmd_data  output  FRAME_BITS-DATA_BITS  command bits (channel select) received in the first MOSI bits of the frame.
REQ-015 Port cmd_valid  output  1  one-clk pulse; cmd_data is updated on this cycle.
REQ-016 Port frame_error  output  1  one-clk pulse when CS deasserts mid-frame.

Function
REQ-017 spi_cs_n, spi_sck and spi_mosi SHALL each pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized signals only.
REQ-018 Holding register: loads sample_data on a valid&&ready cycle; sample_ready SHALL drop the cycle after the load.
REQ-019 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-020 IDLE->SHIFT SHALL occur on a synchronized CS falling edge.
- Same cycle: the shift register loads {empty, 0..., held_data}, where empty=1 and held_data is all zeros if the holding register is empty.
- The holding register is then marked empty, so sample_ready rises the next cycle.
REQ-021 If sample_valid&&sample_ready coincides with the CS falling edge, the new sample SHALL NOT enter this frame; it SHALL be held for the next frame.
REQ-022 In SHIFT:
- Each synchronized SCK rising edge SHALL shift the synchronized MOSI into the receive register and increment the bit counter.
- Each synchronized SCK falling edge SHALL shift the transmit register left.
- spi_miso SHALL equal the transmit register MSB at all times.
REQ-023 SHIFT->DONE SHALL occur when the bit counter reaches FRAME_BITS on a rising edge; the falling edge after the last rising edge SHALL NOT shift the transmit register.
REQ-024 DONE SHALL last exactly one clk:
- cmd_data := receive register bits [FRAME_BITS-1:DATA_BITS] (first-received bit is the MSB).
- cmd_valid SHALL pulse in that clk.
- The FSM SHALL then go to IDLE, ignoring the remaining receive bits.
REQ-025 A synchronized CS rising edge in SHIFT with counter < FRAME_BITS SHALL:
- pulse frame_error;
- go to IDLE;
- leave cmd_data unchanged and not pulse cmd_valid;
- discard the sample without returning it to the holding register.
REQ-026 SCK edges received while CS is high SHALL be ignored.
REQ-027 spi_miso_oe SHALL be high from the cycle after the CS-fall detection until the cycle after the CS-rise detection.
- CS rise in IDLE after a completed frame (DONE already returned to IDLE) SHALL only drop spi_miso_oe.
- CS rise in SHIFT (REQ-025) SHALL drop spi_miso_oe the cycle after detection while the FSM returns to IDLE.
REQ-028 spi_miso SHALL be 0 whenever spi_miso_oe is low.
REQ-029 The bit counter SHALL be ceil(log2(FRAME_BITS+1)) bits wide and SHALL clear on entry to SHIFT; it SHALL NOT wrap.
REQ-030 Extra SCK edges after DONE and before CS rise SHALL be ignored; the next frame SHALL require a new CS falling edge.
REQ-031 Latency: a pin edge SHALL be acted on SYNC_STAGES+1 clk after it reaches the pin; spi_miso SHALL update 1 clk after falling-edge detection.

Reset
REQ-032 On reset, all outputs SHALL be 0 except sample_ready=1:
- spi_miso=0, spi_miso_oe=0, cmd_data=0, cmd_valid=0, frame_error=0.
- FSM=IDLE, holding register empty, synchronizers at spi_cs_n=1, spi_sck=0, spi_mosi=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame without a frame_error or cmd_valid pulse.
REQ-034 After reset, a frame SHALL start only on a CS falling edge seen after CS is synchronized high.

Verification
REQ-035 Load sample 12'hA5C, run a 16-bit frame with MOSI=16'h3000 -> MISO bits 16'h0A5C, cmd_data=4'h3, one cmd_valid pulse, sample_ready re-asserts.
REQ-036 Run a frame with no sample loaded -> MISO bits 16'h8000, cmd_valid pulses.
REQ-037 Raise CS after 7 SCK cycles -> frame_error pulses once, no cmd_valid, cmd_data unchanged, next full frame is correct.
REQ-038 Drive sample_valid with 12'h123 on the CS-fall detection cycle while the holding register holds 12'h456 -> that frame returns 12'h456, next frame returns 12'h123.
REQ-039 Assert reset at SCK cycle 9 -> all outputs at reset values; the subsequent frame with sample 12'hFFF returns 16'h0FFF.
REQ-040 Toggle SCK 20 times while CS is high, then run a normal frame -> no shifts and no pulses during the toggling; the frame is correct. Repeat with clk = exactly 4x SCK.
